// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard, writeback bypass on reads
// and one-cycle registered read data.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   input  logic             rd_valid,
   output logic             rs_ready,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic             rs_valid,
   input  logic             issue_valid,
   input  logic [AW-1:0]    issue_rd,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic [NREGS-1:0] busy_vec
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy_p0;
   logic [NREGS-1:0] busy_nxt;
   logic             hit1;
   logic             hit2;
   logic             accept;
   logic [XLEN-1:0]  rs1_sel;
   logic [XLEN-1:0]  rs2_sel;
   logic [XLEN-1:0]  rs1_data_p1;
   logic [XLEN-1:0]  rs2_data_p1;
   logic             vld_p1;

   // A same-edge writeback to a source overrides both the busy bit and the stored value.
   function automatic logic [XLEN-1:0] src_sel(input logic [AW-1:0] a, input logic hit);
      if (hit)
         return wb_data;
      if (a == '0)
         return '0;
      return regs[a];
   endfunction

   always_comb begin
      hit1     = wb_valid && (wb_addr == rs1_addr) && (rs1_addr != '0);
      hit2     = wb_valid && (wb_addr == rs2_addr) && (rs2_addr != '0);
      rs_ready = !((busy_p0[rs1_addr] && !hit1) || (busy_p0[rs2_addr] && !hit2));
      accept   = rd_valid && rs_ready;
      rs1_sel  = src_sel(rs1_addr, hit1);
      rs2_sel  = src_sel(rs2_addr, hit2);
   end

   // Priority low to high: flush, writeback clear, issue set.
   always_comb begin
      busy_nxt = busy_p0;
      if (flush)
         busy_nxt = '0;
      if (wb_valid)
         busy_nxt[wb_addr] = 1'b0;
      if (issue_valid && (issue_rd != '0))
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wb_valid && (wb_addr != '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         busy_p0 <= '0;
      else
         busy_p0 <= busy_nxt;
   end

   // Stage p0 -> p1: registered read data, updated only on an accepted read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1      <= 1'b0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
      end else begin
         vld_p1 <= accept;
         if (accept) begin
            rs1_data_p1 <= rs1_sel;
            rs2_data_p1 <= rs2_sel;
         end
      end
   end

   assign rs_valid = vld_p1;
   assign rs1_data = rs1_data_p1;
   assign rs2_data = rs2_data_p1;
   assign busy_vec = busy_p0;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb: per-cycle stimulus with
// hand-computed expectations, plus an asynchronous reset sequence.
module tb_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic             clk;
   logic             reset;
   logic [AW-1:0]    rs1_addr, rs2_addr;
   logic             rd_valid;
   logic             rs_ready;
   logic [XLEN-1:0]  rs1_data, rs2_data;
   logic             rs_valid;
   logic             issue_valid;
   logic [AW-1:0]    issue_rd;
   logic             wb_valid;
   logic [AW-1:0]    wb_addr;
   logic [XLEN-1:0]  wb_data;
   logic             flush;
   logic [NREGS-1:0] busy_vec;

   int errors = 0;
   int checks = 0;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_valid(rd_valid),
      .rs_ready(rs_ready), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs_valid(rs_valid), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .busy_vec(busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            rd_valid;
      logic [AW-1:0]   rs1, rs2;
      logic            issue_valid;
      logic [AW-1:0]   issue_rd;
      logic            wb_valid;
      logic [AW-1:0]   wb_addr;
      logic [XLEN-1:0] wb_data;
      logic            flush;
      logic            e_ready;
      logic            e_valid;
      logic [XLEN-1:0] e_d1, e_d2;
      logic [NREGS-1:0] e_busy;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(input logic rv, input int r1, input int r2,
                               input logic iv, input int ird,
                               input logic wv, input int wa, input logic [XLEN-1:0] wd,
                               input logic fl, input logic er, input logic ev,
                               input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                               input logic [NREGS-1:0] eb);
      vec_t v;
      v.rd_valid = rv; v.rs1 = AW'(r1); v.rs2 = AW'(r2);
      v.issue_valid = iv; v.issue_rd = AW'(ird);
      v.wb_valid = wv; v.wb_addr = AW'(wa); v.wb_data = wd; v.flush = fl;
      v.e_ready = er; v.e_valid = ev; v.e_d1 = d1; v.e_d2 = d2; v.e_busy = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      rd_valid = 0; rs1_addr = '0; rs2_addr = '0;
      issue_valid = 0; issue_rd = '0;
      wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0;
   endtask

   initial begin
      //        rv r1 r2 iv ird wv wa wdata         fl rdy vld d1            d2            busy
      vecs[0]  = mk(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 0, 32'h0,        32'h0,        32'h0);
      vecs[1]  = mk(1, 5, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 32'hDEADBEEF, 32'h0,        32'h0);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h0,        32'h0);
      vecs[3]  = mk(0, 0, 0, 1, 7, 0, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF, 32'h0,        32'h80);
      vecs[4]  = mk(1, 7, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'h0,        32'h80);
      vecs[5]  = mk(1, 7, 0, 0, 0, 1, 7, 32'h11,       0, 1, 1, 32'h11,       32'h0,        32'h0);
      vecs[6]  = mk(0, 0, 0, 1, 3, 1, 3, 32'h22,       0, 1, 0, 32'h11,       32'h0,        32'h8);
      vecs[7]  = mk(1, 3, 5, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h11,       32'h0,        32'h8);
      vecs[8]  = mk(0, 0, 0, 1, 4, 0, 0, 32'h0,        0, 1, 0, 32'h11,       32'h0,        32'h18);
      vecs[9]  = mk(0, 0, 0, 1, 9, 0, 0, 32'h0,        0, 1, 0, 32'h11,       32'h0,        32'h218);
      vecs[10] = mk(0, 0, 0, 1, 9, 0, 0, 32'h0,        1, 1, 0, 32'h11,       32'h0,        32'h200);
      vecs[11] = mk(1, 3, 5, 0, 0, 0, 0, 32'h0,        0, 1, 1, 32'h22,       32'hDEADBEEF, 32'h200);
      vecs[12] = mk(1, 0, 7, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 1, 1, 32'h0,        32'h11,       32'h200);
      vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 32'h0,        32'h0,        32'h200);
      vecs[14] = mk(1, 9, 0, 1, 9, 1, 9, 32'h99,       0, 1, 1, 32'h99,       32'h0,        32'h200);
      vecs[15] = mk(1, 0, 9, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h99,       32'h0,        32'h200);
      vecs[16] = mk(0, 0, 0, 0, 0, 1, 9, 32'h55,       0, 1, 0, 32'h99,       32'h0,        32'h0);
      vecs[17] = mk(1, 9, 9, 0, 0, 0, 0, 32'h0,        0, 1, 1, 32'h55,       32'h55,       32'h0);
      vecs[18] = mk(1, 5, 3, 0, 0, 1, 5, 32'h1234,     0, 1, 1, 32'h1234,     32'h22,       32'h0);

      idle();
      reset = 0;
      repeat (2) @(negedge clk);
      chk("reset_rs_valid", 64'(rs_valid), 64'd0);
      chk("reset_rs1_data", 64'(rs1_data), 64'd0);
      chk("reset_busy_vec", 64'(busy_vec), 64'd0);
      reset = 1;
      @(negedge clk);
      chk("idle_rs_ready", 64'(rs_ready), 64'd1);

      for (int i = 0; i < 19; i++) begin
         rd_valid = vecs[i].rd_valid; rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
         issue_valid = vecs[i].issue_valid; issue_rd = vecs[i].issue_rd;
         wb_valid = vecs[i].wb_valid; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
         flush = vecs[i].flush;
         #1;
         chk($sformatf("v%0d_rs_ready", i), 64'(rs_ready), 64'(vecs[i].e_ready));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rs_valid", i), 64'(rs_valid), 64'(vecs[i].e_valid));
         chk($sformatf("v%0d_rs1_data", i), 64'(rs1_data), 64'(vecs[i].e_d1));
         chk($sformatf("v%0d_rs2_data", i), 64'(rs2_data), 64'(vecs[i].e_d2));
         chk($sformatf("v%0d_busy_vec", i), 64'(busy_vec), 64'(vecs[i].e_busy));
         @(negedge clk);
      end

      // Asynchronous reset between edges with busy bits set and rs_valid high.
      idle();
      rd_valid = 1; rs1_addr = 5; rs2_addr = 3; issue_valid = 1; issue_rd = 6;
      @(posedge clk);
      #1;
      chk("pre_rst_rs_valid", 64'(rs_valid), 64'd1);
      chk("pre_rst_busy_vec", 64'(busy_vec), 64'h40);
      chk("pre_rst_rs1_data", 64'(rs1_data), 64'h1234);
      idle();
      #2;
      reset = 0;
      #1;
      chk("arst_rs_valid", 64'(rs_valid), 64'd0);
      chk("arst_rs1_data", 64'(rs1_data), 64'd0);
      chk("arst_rs2_data", 64'(rs2_data), 64'd0);
      chk("arst_busy_vec", 64'(busy_vec), 64'd0);
      chk("arst_rs_ready", 64'(rs_ready), 64'd1);
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      #1;
      chk("post_rel_rs_valid", 64'(rs_valid), 64'd0);
      @(negedge clk);

      for (int r = 1; r < NREGS; r += 2) begin
         rd_valid = 1; rs1_addr = AW'(r); rs2_addr = AW'(r + 1);
         @(posedge clk);
         #1;
         chk($sformatf("clr_x%0d", r), 64'(rs1_data), 64'd0);
         chk($sformatf("clr_x%0d", r + 1), 64'(rs2_data), 64'd0);
         chk($sformatf("clr_vld_%0d", r), 64'(rs_valid), 64'd1);
         @(negedge clk);
      end
      idle();
      @(posedge clk);
      #1;
      chk("final_rs_valid", 64'(rs_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
